// File: rtl/spi_master_cfg_if.sv
// spi_master_cfg_if: host-side TX valid/ready and RX strobe bundle for the SPI master
interface spi_master_cfg_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_last;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  modport master (output tx_valid, tx_data, tx_last, input tx_ready, rx_valid, rx_data);
  modport slave (input tx_valid, tx_data, tx_last, output tx_ready, rx_valid, rx_data);
endinterface

// File: rtl/spi_master_cfg.sv
// spi_master_cfg: SPI master with configurable width, CPOL/CPHA, bit order, divider and burst CS hold
module spi_master_cfg #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8,
  parameter int NUM_SS = 2,
  parameter int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DIV_W-1:0]  div,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [SS_W-1:0]   cs_sel,
  spi_master_cfg_if.slave   host,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);
  localparam int EW = $clog2(2 * DATA_W);
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, HOLD, GAP} state_t;
  state_t state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [EW-1:0] ecnt_q, ecnt_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d, tx_nx, rx_nx;
  logic [SS_W-1:0] cs_q, cs_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, last_q, last_d;
  logic sclk_q, sclk_d, mosi_q, mosi_d, rx_valid_q, rx_valid_d;
  logic tx_ready_q, tx_ready_d, busy_q, busy_d;
  logic tick, accept, odd, fin, smp, shf;
  always_comb begin
    tick = cnt_q == div_q;
    accept = host.tx_valid & tx_ready_q;
    odd = ~ecnt_q[0];
    fin = ecnt_q == EW'(2 * DATA_W - 1);
    smp = cpha_q ? ~odd : odd;
    shf = cpha_q ? odd & (ecnt_q != '0) : ~odd & ~fin;
    tx_nx = lsb_q ? tx_sr_q >> 1 : tx_sr_q << 1;
    rx_nx = lsb_q ? {miso, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], miso};
    state_d = state_q;
    cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    div_d = div_q;
    ecnt_d = ecnt_q;
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    rx_data_d = rx_data_q;
    cs_d = cs_q;
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    lsb_d = lsb_q;
    last_d = last_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    rx_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        sclk_d = cpol;
        if (accept) begin
          state_d = LEAD;
          tx_sr_d = host.tx_data;
          last_d = host.tx_last;
          cs_d = cs_sel;
          cpol_d = cpol;
          cpha_d = cpha;
          lsb_d = lsb_first;
          div_d = div;
          mosi_d = lsb_first ? host.tx_data[0] : host.tx_data[DATA_W-1];
        end
      end
      LEAD: if (tick) begin
        state_d = SHIFT;
        ecnt_d = '0;
      end
      SHIFT: if (tick) begin
        sclk_d = ~sclk_q;
        ecnt_d = ecnt_q + EW'(1);
        if (smp) rx_sr_d = rx_nx;
        if (shf) begin
          tx_sr_d = tx_nx;
          mosi_d = lsb_q ? tx_nx[0] : tx_nx[DATA_W-1];
        end
        if (fin) begin
          state_d = TRAIL;
          rx_valid_d = 1'b1;
          rx_data_d = rx_sr_d;
        end
      end
      TRAIL: if (tick) state_d = last_q ? GAP : HOLD;
      HOLD: if (accept) begin
        state_d = SHIFT;
        ecnt_d = '0;
        tx_sr_d = host.tx_data;
        last_d = host.tx_last;
        mosi_d = lsb_q ? host.tx_data[0] : host.tx_data[DATA_W-1];
      end
      GAP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    busy_d = state_d != IDLE;
    tx_ready_d = state_d == IDLE || state_d == HOLD;
    // an out-of-range select runs the frame with every line deasserted
    ss_n_d = (state_d == IDLE || state_d == GAP || 32'(cs_d) >= NUM_SS) ? '1 : ~(NUM_SS'(1) << cs_d);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      div_q <= '0;
      ecnt_q <= '0;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
      rx_data_q <= '0;
      cs_q <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      lsb_q <= 1'b0;
      last_q <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q <= 1'b0;
      ss_n_q <= '1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      ecnt_q <= ecnt_d;
      tx_sr_q <= tx_sr_d;
      rx_sr_q <= rx_sr_d;
      rx_data_q <= rx_data_d;
      cs_q <= cs_d;
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
      lsb_q <= lsb_d;
      last_q <= last_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      busy_q <= busy_d;
      ss_n_q <= ss_n_d;
    end
  end
  assign host.tx_ready = tx_ready_q;
  assign host.rx_valid = rx_valid_q;
  assign host.rx_data = rx_data_q;
  assign busy = busy_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign ss_n = ss_n_q;
endmodule
